// File: rtl/shift_pkg.sv
// Shared constants for the universal shift register: mode/direction codes and FSM states.
package shift_pkg;

  localparam logic [1:0] MODE_LOG  = 2'b00;
  localparam logic [1:0] MODE_ROT  = 2'b01;
  localparam logic [1:0] MODE_ARI  = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  localparam logic DIR_L = 1'b0;
  localparam logic DIR_R = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational one-step shifter: logical, rotate or arithmetic in either direction.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             sin,
  output logic [WIDTH-1:0] next,
  output logic             out_bit
);

  always_comb begin
    next    = value;
    out_bit = 1'b0;
    case (mode)
      MODE_LOG: begin
        if (dir == DIR_L) begin
          next    = {value[WIDTH-2:0], sin};
          out_bit = value[WIDTH-1];
        end else begin
          next    = {sin, value[WIDTH-1:1]};
          out_bit = value[0];
        end
      end
      MODE_ROT: begin
        if (dir == DIR_L) begin
          next    = {value[WIDTH-2:0], value[WIDTH-1]};
          out_bit = value[WIDTH-1];
        end else begin
          next    = {value[0], value[WIDTH-1:1]};
          out_bit = value[0];
        end
      end
      MODE_ARI: begin
        if (dir == DIR_L) begin
          next    = {value[WIDTH-2:0], 1'b0};
          out_bit = value[WIDTH-1];
        end else begin
          next    = {value[WIDTH-1], value[WIDTH-1:1]};
          out_bit = value[0];
        end
      end
      default: begin
        next    = value;
        out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_reg_seq.sv
// Universal shift register with parallel load, single step and counted burst shifting.
//   state | meaning
//   IDLE  | accepts start > load > shift; done pulses the cycle after a burst ends
//   RUN   | one step per clock using latched controls until rem reaches terminal count
module shift_reg_seq
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d_in,
  input  logic             shift,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             sin,
  input  logic             start,
  input  logic [CNT_W-1:0] cnt,
  output logic [WIDTH-1:0] d_out,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic [1:0]       mode_q, mode_d;
  logic             sin_q, sin_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             sout_q, sout_d;
  logic             done_q, done_d;

  logic             step_dir, step_sin, step_out;
  logic [1:0]       step_mode;
  logic [WIDTH-1:0] step_next;

  // One shifter serves both paths; a running burst uses its latched controls.
  assign step_dir  = (state_q == RUN) ? dir_q  : dir;
  assign step_mode = (state_q == RUN) ? mode_q : mode;
  assign step_sin  = (state_q == RUN) ? sin_q  : sin;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .value   (data_q),
    .dir     (step_dir),
    .mode    (step_mode),
    .sin     (step_sin),
    .next    (step_next),
    .out_bit (step_out)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    sin_d   = sin_q;
    data_d  = data_q;
    sout_d  = sout_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (cnt != '0) begin
            dir_d   = dir;
            mode_d  = mode;
            sin_d   = sin;
            rem_d   = cnt;
            state_d = RUN;
          end else begin
            done_d = 1'b1;
          end
        end else if (load) begin
          data_d = d_in;
        end else if (shift) begin
          data_d = step_next;
          if (mode != MODE_HOLD) sout_d = step_out;
        end
      end
      RUN: begin
        data_d = step_next;
        if (mode_q != MODE_HOLD) sout_d = step_out;
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      dir_q   <= DIR_L;
      mode_q  <= MODE_LOG;
      sin_q   <= 1'b0;
      data_q  <= '0;
      sout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      sin_q   <= sin_d;
      data_q  <= data_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
    end
  end

  assign d_out = data_q;
  assign sout  = sout_q;
  assign busy  = (state_q == RUN);
  assign done  = done_q;

endmodule

// File: tb/tb_shift_reg_seq.sv
// Directed bench for shift_reg_seq (WIDTH=8, CNT_W=4) with hand-computed expectations.
module tb_shift_reg_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [7:0] d_in = 8'h00;
  logic       shift = 1'b0;
  logic       dir = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       sin = 1'b0;
  logic       start = 1'b0;
  logic [3:0] cnt = 4'd0;
  logic [7:0] d_out;
  logic       sout, busy, done;

  int total = 0;
  int bad   = 0;
  int done_seen;

  shift_reg_seq #(.WIDTH(8), .CNT_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .d_in  (d_in),
    .shift (shift),
    .dir   (dir),
    .mode  (mode),
    .sin   (sin),
    .start (start),
    .cnt   (cnt),
    .d_out (d_out),
    .sout  (sout),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] rr_exp [3];
    logic [7:0] ar_exp [4];
    rr_exp = '{8'hC0, 8'h60, 8'h30};
    ar_exp = '{8'hC8, 8'hE4, 8'hF2, 8'hF9};

    // reset
    tick(); tick();
    chk("rst_dout", 32'(d_out), 32'h00);
    chk("rst_sout", 32'(sout), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    rst = 1'b0;

    load = 1'b1; d_in = 8'h55;
    tick();
    load = 1'b0;
    chk("load55", 32'(d_out), 32'h55);

    // single steps
    shift = 1'b1; dir = 1'b0; mode = 2'b00; sin = 1'b1;
    tick();
    chk("ll_dout", 32'(d_out), 32'hAB);
    chk("ll_sout", 32'(sout), 32'h0);
    dir = 1'b1; sin = 1'b0;
    tick();
    chk("lr_dout", 32'(d_out), 32'h55);
    chk("lr_sout", 32'(sout), 32'h1);
    mode = 2'b11;
    tick();
    shift = 1'b0;
    chk("hold_dout", 32'(d_out), 32'h55);
    chk("hold_sout", 32'(sout), 32'h1);

    // rotate right burst of 3; live controls changed during burst must not matter
    load = 1'b1; d_in = 8'h81;
    tick();
    load = 1'b0;
    start = 1'b1; mode = 2'b01; dir = 1'b1; cnt = 4'd3;
    tick();
    start = 1'b0; mode = 2'b00; dir = 1'b0; sin = 1'b1;
    chk("rr_busy0", 32'(busy), 32'h1);
    chk("rr_dout0", 32'(d_out), 32'h81);
    for (int i = 0; i < 3; i++) begin
      if (i < 2) chk("rr_busy", 32'(busy), 32'h1);
      tick();
      chk($sformatf("rr_step%0d", i), 32'(d_out), 32'(rr_exp[i]));
    end
    chk("rr_sout", 32'(sout), 32'h0);
    chk("rr_busy_end", 32'(busy), 32'h0);
    chk("rr_done", 32'(done), 32'h1);
    tick();
    chk("rr_done_clr", 32'(done), 32'h0);

    // arithmetic right burst of 4 with load/shift held
    load = 1'b1; d_in = 8'h90;
    tick();
    start = 1'b1; mode = 2'b10; dir = 1'b1; cnt = 4'd4; d_in = 8'h00; shift = 1'b1;
    tick();
    start = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) done_seen++;
      chk($sformatf("ar_step%0d", i), 32'(d_out), 32'(ar_exp[i]));
    end
    load = 1'b0; shift = 1'b0;
    chk("ar_sout", 32'(sout), 32'h0);
    tick();
    if (done) done_seen++;
    chk("ar_done_once", 32'(done_seen), 32'd1);
    chk("ar_hold", 32'(d_out), 32'hF9);

    // zero-length burst
    start = 1'b1; cnt = 4'd0;
    tick();
    start = 1'b0;
    chk("z_done", 32'(done), 32'h1);
    chk("z_busy", 32'(busy), 32'h0);
    chk("z_dout", 32'(d_out), 32'hF9);
    tick();
    chk("z_done_clr", 32'(done), 32'h0);

    // rotate left by WIDTH restores the value
    load = 1'b1; d_in = 8'hA5;
    tick();
    load = 1'b0;
    start = 1'b1; mode = 2'b01; dir = 1'b0; cnt = 4'd8;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (busy !== 1'b1 || done !== 1'b0) chk("rl_busy", {busy, done}, 32'h2);
    end
    tick();
    chk("rl_dout", 32'(d_out), 32'hA5);
    chk("rl_sout", 32'(sout), 32'h1);
    chk("rl_done", {busy, done}, 32'h1);

    // back-to-back start accepted in the done cycle
    start = 1'b1; mode = 2'b00; dir = 1'b0; sin = 1'b1; cnt = 4'd1;
    tick();
    start = 1'b0;
    chk("bb_busy", {busy, done}, 32'h2);
    tick();
    chk("bb_dout", 32'(d_out), 32'h4B);
    chk("bb_done", {busy, done}, 32'h1);

    // reset in the middle of a long burst
    start = 1'b1; mode = 2'b00; dir = 1'b0; sin = 1'b0; cnt = 4'd10;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("mr_dout_pre", 32'(d_out), 32'h58);
    #2 rst = 1'b1;
    #1;
    chk("mr_dout", 32'(d_out), 32'h00);
    chk("mr_flags", {sout, busy, done}, 32'h0);
    tick();
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done || busy) done_seen++;
    end
    chk("mr_no_done", 32'(done_seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_reg_seq.md
# shift_reg_seq

Parametrised universal shift register with parallel load, single-step shift, and a counted burst-shift sequencer. Supports left and right direction with logical, rotate and arithmetic modes. A start/busy/done handshake lets a controller request N shifts and be told when they finish. It replaces the fixed 8-bit load/shift register in datapaths that need variable width, both directions or multi-bit shifts.

## Interface

- WIDTH, 8, register width in bits (≥2)
- CNT_W, 4, width of the burst count input

- clk  in  1  clock; rising edge active
- rst  in  1  asynchronous, active-high reset
- load  in  1  parallel load of d_in (idle only)
- d_in  in  WIDTH  parallel load data
- shift  in  1  single-step shift (idle only)
- dir  in  1  0 = left (toward MSB), 1 = right
- mode  in  2  00 logical, 01 rotate, 10 arithmetic, 11 hold
- sin  in  1  serial fill bit in logical mode
- start  in  1  begin a burst of cnt shifts
- cnt  in  CNT_W  burst length, 0..2^CNT_W-1
- d_out  out  WIDTH  register contents
- sout  out  1  last bit shifted or rotated out
- busy  out  1  high while a burst is running
- done  out  1  one-cycle pulse when a burst completes

## Operation

- Reset: d_out=0, sout=0, busy=0, done=0, state IDLE.
- One-step shift rules:
  - Logical left: {d[W-2:0],sin}; sout=d[W-1].
  - Logical right: {sin,d[W-1:1]}; sout=d[0].
  - Rotate left/right: wrap-around; sout is the bit that wrapped.
  - Arithmetic left: 0 fill at LSB; sout=d[W-1].
  - Arithmetic right: MSB replicated; sout=d[0].
  - Mode 11: d_out and sout unchanged (a burst still counts and signals done).
- IDLE priority: start > load > shift > hold.
  - load: d_out←d_in; sout unchanged.
  - shift: one step using current dir/mode/sin.
- start with cnt≥1: latch dir, mode, sin and cnt into rem; go to RUN.
- start with cnt=0: stay IDLE; done pulses next cycle; busy stays 0.
- RUN: one step per clock; rem decrements. On the step where rem==1, return to IDLE and register done=1.
- In RUN, load, shift, start and live dir/mode/sin are ignored.
- sout updates only on steps and otherwise holds its value.
- cnt>WIDTH is legal. A rotate burst of WIDTH restores the original value.

## Timing

- load/shift: result visible after the sampling edge (latency 1).
- start sampled at edge k (cnt=N≥1):
  - busy=1 after edge k.
  - Shifts occur at edges k+1..k+N.
  - After edge k+N: busy=0, done=1 for exactly one cycle.
- A new start is accepted in the cycle where done=1; back-to-back bursts have no bubble beyond the one start cycle.
- Reset asserted mid-burst: all outputs clear immediately (asynchronous). No done follows.
- done and busy are never high together.

## Structure

- Package shift_pkg:
  - Mode constants: MODE_LOG, MODE_ROT, MODE_ARI, MODE_HOLD.
  - Direction constants: DIR_L, DIR_R.
  - FSM state encoding: IDLE, RUN.
- Sub-module shift_step: combinational one-step shifter with inputs (value, dir, mode, sin) and outputs (next, out_bit). Instantiated once and shared by single-step and burst paths.
- Top level holds the FSM, rem counter, latched controls and output registers.

## Test plan

(WIDTH=8, CNT_W=4)

- Reset, then load 0x55 → d_out=0x00, sout=0, busy=0, done=0 during reset; d_out=0x55 one edge after load.
- Single shift, logical left, sin=1, on 0x55 → d_out=0xAB, sout=0. Then logical right, sin=0 → 0x55, sout=1.
- Load 0x81, start rotate right, cnt=3 → 0xC0, 0x60, 0x30 on successive edges, sout=0; busy high 3 cycles; done high 1 cycle after.
- Load 0x90, start arithmetic right, cnt=4, with load=1 and shift=1 held during busy → final 0xF9, inputs ignored, done once.
- start cnt=0 → done next cycle, busy never high, d_out unchanged. Load 0xA5, rotate left cnt=8 → d_out=0xA5 after 8 cycles.
- Start logical left cnt=10 and assert rst at the 4th cycle → d_out=0, busy=0, done=0 immediately; no done pulse after rst releases.
